// File: rtl/data_memory_responder.sv
// Two-beat data-memory responder: full-word requests served over a half-width array.
// Optional macro DMEM_RESET_CLEAR_EN adds a post-reset CLEAR sweep that zeroes the array.
`ifndef MEMORY_WIDTH
`define MEMORY_WIDTH 32
`endif
`ifndef MEMORY_DEPTH
`define MEMORY_DEPTH 256
`endif

module data_memory_responder #(
  parameter int memory_width = `MEMORY_WIDTH,
  parameter int memory_depth = `MEMORY_DEPTH
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic                              i_we,
  input  logic                              i_re,
  input  logic [$clog2(memory_depth)-1:0]   i_address,
  input  logic [memory_width-1:0]           i_data_in,
  output logic                              o_busy,
  output logic                              o_valid,
  output logic [memory_width/2-1:0]         o_mem_l,
  output logic [memory_width/2-1:0]         o_mem_h
);

  localparam int half_width  = memory_width / 2;
  localparam int addr_width  = $clog2(memory_depth);
  localparam int entry_count = 2 * memory_depth;
  localparam int entry_width = addr_width + 1;

`ifdef DMEM_RESET_CLEAR_EN
  typedef enum logic [2:0] {IDLE, BEAT_L, BEAT_H, RESP, CLEAR} state_t;
`else
  typedef enum logic [1:0] {IDLE, BEAT_L, BEAT_H, RESP} state_t;
`endif

  state_t                  state;
  logic [addr_width-1:0]   req_addr;
  logic [memory_width-1:0] req_data;
  logic                    req_we;
  logic                    req_re;
  logic [half_width-1:0]   hold_l;

  logic [half_width-1:0]   mem [entry_count];

  logic [entry_width-1:0]  entry_idx;
  logic [half_width-1:0]   beat_data;
  logic [half_width-1:0]   rd_beat;
  logic                    wr_en;
  logic [entry_width-1:0]  wr_idx;
  logic [half_width-1:0]   wr_data;

`ifdef DMEM_RESET_CLEAR_EN
  logic [entry_width-1:0]  clr_cnt;
`endif

  // A write-and-read request returns the written half rather than the old contents.
  always_comb begin
    entry_idx = {req_addr, (state == BEAT_H)};
    beat_data = (state == BEAT_H) ? req_data[memory_width-1:half_width]
                                  : req_data[half_width-1:0];
    rd_beat   = req_we ? beat_data : mem[entry_idx];
    wr_en     = 1'b0;
    wr_idx    = entry_idx;
    wr_data   = beat_data;
    if (!i_rst && req_we && (state == BEAT_L || state == BEAT_H))
      wr_en = 1'b1;
`ifdef DMEM_RESET_CLEAR_EN
    if (!i_rst && state == CLEAR) begin
      wr_en   = 1'b1;
      wr_idx  = clr_cnt;
      wr_data = '0;
    end
`endif
  end

  always_ff @(posedge i_clk) begin
    if (wr_en)
      mem[wr_idx] <= wr_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid  <= 1'b0;
      o_mem_l  <= '0;
      o_mem_h  <= '0;
      req_addr <= '0;
      req_data <= '0;
      req_we   <= 1'b0;
      req_re   <= 1'b0;
      hold_l   <= '0;
`ifdef DMEM_RESET_CLEAR_EN
      // Busy from reset onward so the requester stalls for the whole sweep.
      state    <= CLEAR;
      o_busy   <= 1'b1;
      clr_cnt  <= '0;
`else
      state    <= IDLE;
      o_busy   <= 1'b0;
`endif
    end else begin
      o_valid <= 1'b0;
      o_busy  <= 1'b0;
      case (state)
        IDLE, RESP: begin
          if (i_we || i_re) begin
            req_addr <= i_address;
            req_data <= i_data_in;
            req_we   <= i_we;
            req_re   <= i_re;
            o_busy   <= 1'b1;
            state    <= BEAT_L;
          end else begin
            state <= IDLE;
          end
        end
        BEAT_L: begin
          hold_l <= rd_beat;
          o_busy <= 1'b1;
          state  <= BEAT_H;
        end
        BEAT_H: begin
          if (req_re) begin
            o_mem_l <= hold_l;
            o_mem_h <= rd_beat;
          end
          o_valid <= 1'b1;
          state   <= RESP;
        end
`ifdef DMEM_RESET_CLEAR_EN
        CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == entry_width'(entry_count - 1))
            state <= IDLE;
          else
            o_busy <= 1'b1;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed self-checking bench for data_memory_responder in its default build.
`timescale 1ns/1ps

module tb_data_memory_responder;

  logic        i_clk;
  logic        i_rst;
  logic        i_we;
  logic        i_re;
  logic [7:0]  i_address;
  logic [31:0] i_data_in;
  logic        o_busy;
  logic        o_valid;
  logic [15:0] o_mem_l;
  logic [15:0] o_mem_h;

  int num_checks = 0;
  int num_fails  = 0;

  data_memory_responder #(
    .memory_width(32),
    .memory_depth(256)
  ) dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_we     (i_we),
    .i_re     (i_re),
    .i_address(i_address),
    .i_data_in(i_data_in),
    .o_busy   (o_busy),
    .o_valid  (o_valid),
    .o_mem_l  (o_mem_l),
    .o_mem_h  (o_mem_h)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    num_checks++;
    if (actual !== expected) begin
      num_fails++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic re, input logic [7:0] addr, input logic [31:0] data);
    i_we      = we;
    i_re      = re;
    i_address = addr;
    i_data_in = data;
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // One access from request to RESP; request dropped once accepted.
  task automatic runAccess(input string tag, input logic we, input logic re, input logic [7:0] addr,
                           input logic [31:0] data, input logic chk, input logic [15:0] exp_h,
                           input logic [15:0] exp_l);
    applyStimulus(we, re, addr, data);
    step();
    applyStimulus(1'b0, 1'b0, addr, data);
    checkOutput({tag, "_c1_busy"}, {31'b0, o_busy}, 32'd1);
    checkOutput({tag, "_c1_valid"}, {31'b0, o_valid}, 32'd0);
    step();
    checkOutput({tag, "_c2_busy"}, {31'b0, o_busy}, 32'd1);
    step();
    checkOutput({tag, "_c3_valid"}, {31'b0, o_valid}, 32'd1);
    checkOutput({tag, "_c3_busy"}, {31'b0, o_busy}, 32'd0);
    if (chk) begin
      checkOutput({tag, "_mem_h"}, {16'b0, o_mem_h}, {16'b0, exp_h});
      checkOutput({tag, "_mem_l"}, {16'b0, o_mem_l}, {16'b0, exp_l});
    end
  endtask

  initial begin
    i_rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 8'd0, 32'd0);
    step();
    step();
    checkOutput("rst_busy",  {31'b0, o_busy},  32'd0);
    checkOutput("rst_valid", {31'b0, o_valid}, 32'd0);
    checkOutput("rst_mem_l", {16'b0, o_mem_l}, 32'd0);
    checkOutput("rst_mem_h", {16'b0, o_mem_h}, 32'd0);
    i_rst = 1'b0;
    step();
    checkOutput("post_rst_busy", {31'b0, o_busy}, 32'd0);
    step();
    checkOutput("idle_valid", {31'b0, o_valid}, 32'd0);

    // Write then read word 5; a write leaves the read outputs untouched.
    runAccess("wr5", 1'b1, 1'b0, 8'd5, 32'hDEADBEEF, 1'b1, 16'h0000, 16'h0000);
    step();
    checkOutput("after_wr5_busy", {31'b0, o_busy}, 32'd0);
    runAccess("rd5", 1'b0, 1'b1, 8'd5, 32'h0, 1'b1, 16'hDEAD, 16'hBEEF);

    // Back-to-back reads of 1 and 2 with the read request held high.
    runAccess("wr1", 1'b1, 1'b0, 8'd1, 32'hA1A1B1B1, 1'b0, 16'h0, 16'h0);
    runAccess("wr2", 1'b1, 1'b0, 8'd2, 32'hC2C2D2D2, 1'b0, 16'h0, 16'h0);
    step();
    applyStimulus(1'b0, 1'b1, 8'd1, 32'h0);
    step();
    checkOutput("b2b_c1_busy", {31'b0, o_busy}, 32'd1);
    step();
    checkOutput("b2b_c2_busy", {31'b0, o_busy}, 32'd1);
    step();
    checkOutput("b2b_c3_valid", {31'b0, o_valid}, 32'd1);
    checkOutput("b2b_c3_mem_h", {16'b0, o_mem_h}, 32'h0000A1A1);
    checkOutput("b2b_c3_mem_l", {16'b0, o_mem_l}, 32'h0000B1B1);
    applyStimulus(1'b0, 1'b1, 8'd2, 32'h0);
    step();
    checkOutput("b2b_c4_busy",  {31'b0, o_busy},  32'd1);
    checkOutput("b2b_c4_valid", {31'b0, o_valid}, 32'd0);
    step();
    checkOutput("b2b_c5_busy", {31'b0, o_busy}, 32'd1);
    step();
    applyStimulus(1'b0, 1'b0, 8'd0, 32'h0);
    checkOutput("b2b_c6_valid", {31'b0, o_valid}, 32'd1);
    checkOutput("b2b_c6_mem_h", {16'b0, o_mem_h}, 32'h0000C2C2);
    checkOutput("b2b_c6_mem_l", {16'b0, o_mem_l}, 32'h0000D2D2);
    step();

    // Simultaneous write and read returns the written word.
    runAccess("wr_rd9", 1'b1, 1'b1, 8'd9, 32'h12345678, 1'b1, 16'h1234, 16'h5678);
    step();
    runAccess("wr4", 1'b1, 1'b0, 8'd4, 32'h55556666, 1'b0, 16'h0, 16'h0);
    runAccess("rd9", 1'b0, 1'b1, 8'd9, 32'h0, 1'b1, 16'h1234, 16'h5678);

    // Address changes while busy are ignored.
    runAccess("wr3", 1'b1, 1'b0, 8'd3, 32'h33334444, 1'b0, 16'h0, 16'h0);
    step();
    applyStimulus(1'b0, 1'b1, 8'd3, 32'h0);
    step();
    applyStimulus(1'b0, 1'b1, 8'd4, 32'h0);
    step();
    applyStimulus(1'b0, 1'b0, 8'd4, 32'h0);
    step();
    checkOutput("rd3_valid", {31'b0, o_valid}, 32'd1);
    checkOutput("rd3_mem_h", {16'b0, o_mem_h}, 32'h00003333);
    checkOutput("rd3_mem_l", {16'b0, o_mem_l}, 32'h00004444);
    step();

    // Reset during BEAT_H keeps the low half write, drops the high half.
    runAccess("wr7_ones", 1'b1, 1'b0, 8'd7, 32'hFFFFFFFF, 1'b0, 16'h0, 16'h0);
    step();
    applyStimulus(1'b1, 1'b0, 8'd7, 32'h00000000);
    step();
    applyStimulus(1'b0, 1'b0, 8'd7, 32'h00000000);
    checkOutput("abort_c1_busy", {31'b0, o_busy}, 32'd1);
    step();
    i_rst = 1'b1;
    step();
    checkOutput("abort_valid", {31'b0, o_valid}, 32'd0);
    checkOutput("abort_busy",  {31'b0, o_busy},  32'd0);
    checkOutput("abort_mem_h", {16'b0, o_mem_h}, 32'd0);
    checkOutput("abort_mem_l", {16'b0, o_mem_l}, 32'd0);
    i_rst = 1'b0;
    step();
    checkOutput("abort_post_valid", {31'b0, o_valid}, 32'd0);
    runAccess("rd7", 1'b0, 1'b1, 8'd7, 32'h0, 1'b1, 16'hFFFF, 16'h0000);
    step();
    checkOutput("final_valid", {31'b0, o_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
    $finish;
  end

endmodule
